// File: rtl/rgb2gray_conv_if.sv
// Bundle of the luma converter's control and memory-side signals.
// The conversion block takes the master view; the environment (demosaic control,
// channel memories, Y memory) takes the slave view.
interface rgb2gray_conv_if #(
  parameter int ADDR_W = 19,
  parameter int DIM_W  = 11
);
  // Control side
  logic              start;
  logic [DIM_W-1:0]  width;
  logic [DIM_W-1:0]  height;
  logic              busy;
  logic              done;

  // R/G/B channel memory read port (shared address, 1-cycle read latency)
  logic [ADDR_W-1:0] addr_rgb;
  logic [7:0]        rdata_r;
  logic [7:0]        rdata_g;
  logic [7:0]        rdata_b;

  // Y memory write port
  logic              wr_y;
  logic [ADDR_W-1:0] addr_y;
  logic [7:0]        wdata_y;

`ifdef GRAY_STATS_EN
  // Per-image luma statistics
  logic [7:0]        y_min;
  logic [7:0]        y_max;
  logic [26:0]       y_sum;
`endif

  modport master (
    input  start, width, height, rdata_r, rdata_g, rdata_b,
    output busy, done, addr_rgb, wr_y, addr_y, wdata_y
`ifdef GRAY_STATS_EN
    , output y_min, y_max, y_sum
`endif
  );

  modport slave (
    output start, width, height, rdata_r, rdata_g, rdata_b,
    input  busy, done, addr_rgb, wr_y, addr_y, wdata_y
`ifdef GRAY_STATS_EN
    , input y_min, y_max, y_sum
`endif
  );
endinterface

// File: rtl/rgb2gray_conv.sv
// RGB to luma conversion: reads R/G/B planes, writes Y = (77R+150G+29B+128)>>8.
// Latency: write of pixel k lands 2 cycles after its read address; start to done is N+3 (N=0: 1).
// No backpressure: one pixel per cycle, memories are assumed always ready.
// Optional build macro GRAY_STATS_EN adds y_min/y_max/y_sum outputs.
module rgb2gray_conv #(
  parameter int ADDR_W = 19,
  parameter int DIM_W  = 11
) (
  input  logic            clk,
  input  logic            reset,
  rgb2gray_conv_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] n_pix;      // pixel count latched at start
  logic [ADDR_W-1:0] rd_cnt;     // read address counter, drives addr_rgb
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] prod_n;     // width*height truncated to the address width
  logic              start_ok;

  // Stage 1: address that is currently being read from the memories
  logic              v1;
  logic [ADDR_W-1:0] addr_d1;

  // Stage 2: registered write port
  logic              wr_q;
  logic [ADDR_W-1:0] addr_y_q;
  logic [7:0]        wdata_q;

  logic [15:0]       acc;
  logic [7:0]        y_calc;

  assign prod_n   = ADDR_W'(bus.width) * ADDR_W'(bus.height);
  assign start_ok = (state == ST_IDLE) && bus.start;
  assign last_idx = n_pix - 1'b1;

  // Weighted sum; weights total 256 so the result never exceeds 255 and fits 16 bits.
  always_comb begin
    acc    = 16'd77  * {8'd0, bus.rdata_r}
           + 16'd150 * {8'd0, bus.rdata_g}
           + 16'd29  * {8'd0, bus.rdata_b}
           + 16'd128;
    y_calc = 8'(acc >> 8);
  end

  // Control FSM and read address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      n_pix  <= '0;
      rd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            n_pix  <= prod_n;
            rd_cnt <= '0;
            state  <= (prod_n != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          // Counter parks on the last address while the pipeline drains.
          if (rd_cnt == last_idx) begin
            state <= ST_DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Once stage 1 is empty, the final write is on the port this cycle.
          if (!v1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: track which address the memory read data belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      addr_d1 <= '0;
    end else begin
      v1      <= (state == ST_RUN);
      addr_d1 <= rd_cnt;
    end
  end

  // Stage 2: register the luma result and its address onto the Y write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      addr_y_q <= '0;
      wdata_q  <= '0;
    end else begin
      wr_q <= v1;
      if (v1) begin
        addr_y_q <= addr_d1;
        wdata_q  <= y_calc;
      end
    end
  end

`ifdef GRAY_STATS_EN
  logic [7:0]  y_min_q;
  logic [7:0]  y_max_q;
  logic [26:0] y_sum_q;

  // Statistics follow the write stream; they move in the same edge as wdata_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_min_q <= 8'hFF;
      y_max_q <= 8'h00;
      y_sum_q <= '0;
    end else if (start_ok) begin
      y_min_q <= 8'hFF;
      y_max_q <= 8'h00;
      y_sum_q <= '0;
    end else if (v1) begin
      if (y_calc < y_min_q) y_min_q <= y_calc;
      if (y_calc > y_max_q) y_max_q <= y_calc;
      y_sum_q <= y_sum_q + 27'(y_calc);
    end
  end

  assign bus.y_min = y_min_q;
  assign bus.y_max = y_max_q;
  assign bus.y_sum = y_sum_q;
`else
  // start_ok only feeds the statistics; keep it referenced in the plain build.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign bus.addr_rgb = rd_cnt;
  assign bus.wr_y     = wr_q;
  assign bus.addr_y   = addr_y_q;
  assign bus.wdata_y  = wdata_q;
  assign bus.busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done     = (state == ST_DONE);

endmodule

// File: doc/rgb2gray_conv.md
Name: rgb2gray_conv

Overview:
- Post-demosaic stage: after the demosaic block finishes, reads the full R, G and B channel memories and writes one 8-bit luma (grayscale) image to a Y memory.
- Started by the demosaic `done` pulse; uses the same width/height convention.
- Streams one pixel per cycle through a 2-stage pipeline: address issue, then weighted sum, then write.

Parameters:
- ADDR_W, 19, pixel address width (same as channel memories).
- DIM_W, 11, width/height field width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin conversion (driven by demosaic done)
- width  in  DIM_W  image width in pixels; sampled on accepted start
- height  in  DIM_W  image height in pixels; sampled on accepted start
- addr_rgb  out  ADDR_W  shared read address to R/G/B memories
- rdata_r  in  8  R memory read data; 1-cycle synchronous read latency
- rdata_g  in  8  G memory read data; 1-cycle synchronous read latency
- rdata_b  in  8  B memory read data; 1-cycle synchronous read latency
- wr_y  out  1  Y memory write enable
- addr_y  out  ADDR_W  Y memory write address
- wdata_y  out  8  luma value
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset (async, any state): FSM goes to IDLE. addr_rgb=0, wr_y=0, addr_y=0, wdata_y=0, busy=0, done=0. Pipeline valids are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches width/height and computes N = width*height as a registered product of width ADDR_W.
  - Next state is RUN if N≠0, otherwise DONE.
  - start is ignored in every other state.
- RUN:
  - addr_rgb = rd_cnt, starting at 0 and incrementing each cycle.
  - Stage-1 valid (v1) is set with addr_d1 = rd_cnt.
  - When rd_cnt == N-1: go to DRAIN, and rd_cnt holds.
- Stage 2, the cycle after v1:
  - Y = (77*R + 150*G + 29*B + 128) >> 8, computed in 16-bit unsigned.
  - Weights sum to 256, so the maximum is 255 and no saturation is needed.
  - The result is registered into wdata_y, with addr_y = addr_d1 and wr_y = v1.
- Write timing: wr_y for pixel k is asserted exactly 2 cycles after addr_rgb = k. Writes occur in ascending address order, contiguous, one per cycle.
- DRAIN: lasts 2 cycles until the pipeline is empty (last write issued), then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy = (state != IDLE && state != DONE).
- Total latency from start to done: N + 3 cycles (N≥1). For N=0, done is asserted 1 cycle after start and there are no writes.
- Outside valid cycles: addr_y and wdata_y hold their last value, wr_y=0.
- width/height changes during RUN have no effect.
- start coincident with done: ignored, since the FSM is not in IDLE.

Optional Feature:
- Macro: GRAY_STATS_EN.
- With the macro defined:
  - Extra output ports: y_min out 8, y_max out 8, y_sum out 27.
  - Updated on every wr_y cycle.
  - On accepted start they reinitialise to y_min=255, y_max=0, y_sum=0.
  - They are valid and stable from the done pulse until the next accepted start.
  - Reset values: 255, 0, 0.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- 2x2 image, R=G=B=100 at all pixels, start pulse → 4 writes at addr 0..3, wdata_y=100. First wr_y 3 cycles after start; done 7 cycles after start.
- 1x1 image, pixel (R,G,B)=(255,0,0) → wdata_y=77. Pixel (0,255,0) → 149. Pixel (0,0,255) → 29. Pixel (255,255,255) → 255.
- width=0, height=5 → no wr_y, done 1 cycle after start, busy stays 0.
- 4x3 random image: second start pulse mid-RUN and width change mid-RUN → ignored; 12 writes matching the golden model; addresses 0..11 contiguous.
- Reset asserted at the 5th RUN cycle of an 8x8 image → wr_y/done/busy drop immediately. A new start afterwards runs a full 64-pixel conversion correctly.
- GRAY_STATS_EN, 2x1 image with pixels Y=10 and Y=200 → at done: y_min=10, y_max=200, y_sum=210.
